// File: rtl/lights_sequencer_if.sv
// Control/status bus between the user inputs and the lights sequencer.
// Compile-time option: LIGHTS_DIR_EN adds the step-direction signal dir.
interface lights_sequencer_if #(
  parameter int NUM_CH   = 2,
  parameter int PERIOD_W = 16
);
  logic                 button;
  logic [1:0]           mode;
  logic [PERIOD_W-1:0]  period;
`ifdef LIGHTS_DIR_EN
  logic                 dir;
`endif
  logic [3*NUM_CH-1:0]  colour;
  logic [24*NUM_CH-1:0] light;
  logic                 step;

`ifdef LIGHTS_DIR_EN
  modport master (output button, mode, period, dir, input  colour, light, step);
  modport slave  (input  button, mode, period, dir, output colour, light, step);
`else
  modport master (output button, mode, period, input  colour, light, step);
  modport slave  (input  button, mode, period, output colour, light, step);
`endif
endinterface

// File: rtl/lights_sequencer.sv
// Multi-channel RGB sequencer: shared base colour index, per-channel phase, four modes.
// Compile-time option: LIGHTS_DIR_EN enables reverse stepping via bus.dir.
module lights_sequencer #(
  parameter int NUM_CH   = 2,
  parameter int PERIOD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  lights_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_WHITE  = 2'b01,
    MODE_MANUAL = 2'b10,
    MODE_AUTO   = 2'b11
  } mode_e;

  localparam logic [2:0]          BASE_RESET = 3'b001;
  localparam logic [PERIOD_W-1:0] TMR_ONE    = PERIOD_W'(1);

  // Channel k runs k positions ahead of the base in the 1..6 cycle.
  function automatic logic [2:0] ch_index(input logic [2:0] base, input int k);
    return 3'((int'(base) + 5 + k) % 6 + 1);
  endfunction

  function automatic logic [3*NUM_CH-1:0] colours_of(input logic [2:0] base);
    logic [3*NUM_CH-1:0] c;
    c = '0;
    for (int k = 0; k < NUM_CH; k++) c[3*k +: 3] = ch_index(base, k);
    return c;
  endfunction

  function automatic logic [23:0] rgb_of(input logic [2:0] idx);
    case (idx)
      3'b001:  return 24'h0000FF;
      3'b010:  return 24'h00FF00;
      3'b011:  return 24'h00FFFF;
      3'b100:  return 24'hFF0000;
      3'b101:  return 24'hFF00FF;
      3'b110:  return 24'hFFFF00;
      default: return 24'h000000;
    endcase
  endfunction

  mode_e                mode;
  logic                 reverse;
  logic                 press;
  logic                 advance;
  logic                 upset;
  logic                 btn_q;
  logic [2:0]           base_q, base_d;
  logic [PERIOD_W-1:0]  tmr_q, tmr_d;
  logic                 step_q, step_d;
  logic [3*NUM_CH-1:0]  colour_q, colour_d;
  logic [24*NUM_CH-1:0] light_q, light_d;

  assign mode  = mode_e'(bus.mode);
  assign press = bus.button & ~btn_q;

`ifdef LIGHTS_DIR_EN
  assign reverse = bus.dir;
`else
  assign reverse = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    base_d  = base_q;
    tmr_d   = '0;
    advance = 1'b0;
    light_d = '0;

    unique case (mode)
      MODE_MANUAL: advance = press;
      MODE_AUTO: begin
        // Comparing with >= makes a lowered period fire on the very next edge.
        if (tmr_q >= bus.period) advance = 1'b1;
        else                     tmr_d   = tmr_q + TMR_ONE;
      end
      default: ;
    endcase

    upset = (base_q == 3'b000) || (base_q == 3'b111);
    if (upset) begin
      base_d = BASE_RESET;
    end else if (advance) begin
      if (reverse) base_d = (base_q == 3'b001) ? 3'b110 : base_q - 3'd1;
      else         base_d = (base_q == 3'b110) ? 3'b001 : base_q + 3'd1;
    end

    step_d   = advance & ~upset;
    colour_d = colours_of(base_d);

    unique case (mode)
      MODE_OFF:   light_d = '0;
      MODE_WHITE: light_d = '1;
      default: begin
        for (int k = 0; k < NUM_CH; k++) light_d[24*k +: 24] = rgb_of(colour_q[3*k +: 3]);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      base_q   <= BASE_RESET;
      btn_q    <= 1'b1;
      tmr_q    <= '0;
      step_q   <= 1'b0;
      colour_q <= colours_of(BASE_RESET);
      light_q  <= '0;
    end else begin
      base_q   <= base_d;
      btn_q    <= bus.button;
      tmr_q    <= tmr_d;
      step_q   <= step_d;
      colour_q <= colour_d;
      light_q  <= light_d;
    end
  end

  assign bus.colour = colour_q;
  assign bus.light  = light_q;
  assign bus.step   = step_q;

endmodule

// File: tb/tb_lights_sequencer.sv
// Self-checking bench for lights_sequencer (NUM_CH=2): vector table, corner sequences, random vs model.
// Compile with LIGHTS_DIR_EN defined to also exercise reverse stepping.
module tb_lights_sequencer;
  localparam int NUM_CH   = 2;
  localparam int PERIOD_W = 16;

  logic clk = 1'b0;
  logic rst;

  lights_sequencer_if #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W)) bus ();

  lights_sequencer #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: base as a position 0..5 ----------------
  logic [23:0] rgb_tab [6];
  initial begin
    rgb_tab[0] = 24'h0000FF; rgb_tab[1] = 24'h00FF00; rgb_tab[2] = 24'h00FFFF;
    rgb_tab[3] = 24'hFF0000; rgb_tab[4] = 24'hFF00FF; rgb_tab[5] = 24'hFFFF00;
  end

  function automatic logic [255:0] model_colour(input int pos);
    logic [255:0] r = '0;
    for (int k = 0; k < NUM_CH; k++) r[3*k +: 3] = 3'((pos + k) % 6 + 1);
    return r;
  endfunction

  function automatic logic [255:0] model_light(input logic [1:0] md, input int pos);
    logic [255:0] r = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (md == 2'b01)      r[24*k +: 24] = 24'hFFFFFF;
      else if (md != 2'b00) r[24*k +: 24] = rgb_tab[(pos + k) % 6];
    end
    return r;
  endfunction

  int           m_pos;
  int           m_tmr;
  bit           m_btnq;
  bit           m_step;
  logic [255:0] m_light;
  logic         dir_in;

`ifdef LIGHTS_DIR_EN
  assign dir_in = bus.dir;
`else
  assign dir_in = 1'b0;
`endif

  wire m_due = (m_tmr >= int'(bus.period));
  wire m_adv = (bus.mode == 2'b10 && bus.button && !m_btnq) || (bus.mode == 2'b11 && m_due);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos   <= 0;
      m_tmr   <= 0;
      m_btnq  <= 1'b1;
      m_step  <= 1'b0;
      m_light <= '0;
    end else begin
      m_btnq  <= bus.button;
      m_light <= model_light(bus.mode, m_pos);
      m_tmr   <= (bus.mode == 2'b11 && !m_due) ? m_tmr + 1 : 0;
      m_step  <= m_adv;
      if (m_adv) m_pos <= dir_in ? (m_pos + 5) % 6 : (m_pos + 1) % 6;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_colour"}, bus.colour, model_colour(m_pos));
    check({tag, "_light"},  bus.light,  m_light);
    check({tag, "_step"},   bus.step,   m_step);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        btn;
    logic [1:0]  mode;
    logic [15:0] period;
    logic [5:0]  colour;
    logic [47:0] light;
    logic        step;
  } vec_t;

  vec_t vecs [13];

  initial begin : main
    int n;
    int steps;

    vecs[0]  = '{1'b0, 2'b10, 16'd0, 6'b010_001, 48'h00FF00_0000FF, 1'b0};
    vecs[1]  = '{1'b1, 2'b10, 16'd0, 6'b011_010, 48'h00FF00_0000FF, 1'b1};
    vecs[2]  = '{1'b1, 2'b10, 16'd0, 6'b011_010, 48'h00FFFF_00FF00, 1'b0};
    vecs[3]  = '{1'b0, 2'b10, 16'd0, 6'b011_010, 48'h00FFFF_00FF00, 1'b0};
    vecs[4]  = '{1'b1, 2'b01, 16'd0, 6'b011_010, 48'hFFFFFF_FFFFFF, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 16'd0, 6'b011_010, 48'h000000_000000, 1'b0};
    vecs[6]  = '{1'b1, 2'b10, 16'd0, 6'b100_011, 48'h00FFFF_00FF00, 1'b1};
    vecs[7]  = '{1'b0, 2'b11, 16'd1, 6'b100_011, 48'hFF0000_00FFFF, 1'b0};
    vecs[8]  = '{1'b0, 2'b11, 16'd1, 6'b101_100, 48'hFF0000_00FFFF, 1'b1};
    vecs[9]  = '{1'b1, 2'b11, 16'd0, 6'b110_101, 48'hFF00FF_FF0000, 1'b1};
    vecs[10] = '{1'b0, 2'b11, 16'd0, 6'b001_110, 48'hFFFF00_FF00FF, 1'b1};
    vecs[11] = '{1'b0, 2'b11, 16'd0, 6'b010_001, 48'h0000FF_FFFF00, 1'b1};
    vecs[12] = '{1'b0, 2'b01, 16'd0, 6'b010_001, 48'hFFFFFF_FFFFFF, 1'b0};

    bus.button = 1'b0;
    bus.mode   = 2'b10;
    bus.period = '0;
`ifdef LIGHTS_DIR_EN
    bus.dir    = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) tick();
    check("reset_colour", bus.colour, 6'b010_001);
    check("reset_light",  bus.light,  '0);
    check("reset_step",   bus.step,   1'b0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      bus.button = vecs[i].btn;
      bus.mode   = vecs[i].mode;
      bus.period = vecs[i].period;
      tick();
      check($sformatf("vec%0d_colour", i), bus.colour, vecs[i].colour);
      check($sformatf("vec%0d_light", i),  bus.light,  vecs[i].light);
      check($sformatf("vec%0d_step", i),   bus.step,   vecs[i].step);
    end

    // Manual: button high 3 cycles then low, six times; exactly one step per press, wrapping.
    bus.mode = 2'b10;
    for (int p = 0; p < 6; p++) begin
      steps = 0;
      bus.button = 1'b1;
      repeat (3) begin tick(); steps += int'(bus.step); end
      bus.button = 1'b0;
      tick(); steps += int'(bus.step);
      check($sformatf("press%0d_steps", p), steps, 1);
      check($sformatf("press%0d_colour", p), bus.colour, model_colour((p + 1) % 6));
    end
    check("manual_wrap_colour", bus.colour, 6'b010_001);

    // Auto, period 3: first step 4 cycles after entry, light one cycle behind colour.
    bus.mode   = 2'b11;
    bus.period = 16'd3;
    n = 0;
    do begin tick(); n++; end while (!bus.step && n < 20);
    check("auto_first_interval", n, 4);
    check("auto_colour_after_step", bus.colour, 6'b011_010);
    check("auto_light_lags", bus.light, 48'h00FF00_0000FF);
    tick();
    check("auto_light_follows", bus.light, 48'h00FFFF_00FF00);
    n = 1;
    do begin tick(); n++; end while (!bus.step && n < 20);
    check("auto_second_interval", n, 4);

    // Lowering period below the running timer advances on the next edge.
    bus.period = 16'd10;
    repeat (5) tick();
    check("long_period_no_step", bus.step, 1'b0);
    bus.period = 16'd2;
    tick();
    check("lowered_period_step", bus.step, 1'b1);

    // Period 0 steps every cycle; switching to WHITE freezes colour.
    bus.period = 16'd0;
    tick();
    check("period0_step_a", bus.step, 1'b1);
    tick();
    check("period0_step_b", bus.step, 1'b1);
    bus.mode = 2'b01;
    tick();
    check("white_light", bus.light, 48'hFFFFFF_FFFFFF);
    check("white_frozen_colour", bus.colour, model_colour(m_pos));
    tick();
    check("white_no_step", bus.step, 1'b0);
    check_model("white_hold");

    // Asynchronous reset in the middle of AUTO, button held high across the release.
    bus.mode = 2'b11;
    tick(); tick();
    bus.button = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_rst_colour", bus.colour, 6'b010_001);
    check("async_rst_light",  bus.light,  '0);
    check("async_rst_step",   bus.step,   1'b0);
    tick();
    rst = 1'b0;
    bus.mode = 2'b10;
    tick(); tick();
    check("held_button_no_step", bus.step, 1'b0);
    check("held_button_colour",  bus.colour, 6'b010_001);
    bus.button = 1'b0;
    tick();

`ifdef LIGHTS_DIR_EN
    bus.dir    = 1'b1;
    bus.button = 1'b1;
    tick();
    check("reverse_step", bus.step, 1'b1);
    check("reverse_colour", bus.colour, 6'b001_110);
    bus.button = 1'b0;
    bus.dir    = 1'b0;
    tick();
`endif

    // Randomized traffic against the model, with rare asynchronous resets.
    check_model("pre_random");
    for (int c = 0; c < 2500; c++) begin
      bus.mode   = 2'($urandom_range(0, 3));
      bus.button = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) bus.period = 16'($urandom_range(0, 6));
`ifdef LIGHTS_DIR_EN
      if ($urandom_range(0, 7) == 0) bus.dir = 1'($urandom_range(0, 1));
`endif
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #2 rst = 1'b0;
      end
      tick();
      check_model($sformatf("rand%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d, errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
